// File: rtl/i2s_line_in_rx_pkg.sv
// Shared types for the I2S line-in receiver.
//   rx_state_t   : receiver FSM states
//   CHAN_LEFT/RIGHT : LRCLK level that selects each channel
package i2s_line_in_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    HOLD      = 2'd2
  } rx_state_t;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_line_in_rx_sync_edge_detect.sv
// N-stage synchronizer for an asynchronous input plus a rising-edge strobe
// taken between the last synchronizer flop and one extra delay flop.
//   clk   : sampling clock
//   reset : asynchronous, active-high
//   din   : asynchronous input
//   rise  : one-clk pulse per synchronized 0->1 transition of din
module i2s_line_in_rx_sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              din_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      din_d <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      din_d <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~din_d;

endmodule

// File: rtl/i2s_line_in_rx.sv
// ADAU1761 line-in I2S receiver. Oversamples BCLK/LRCLK/SDATA in the clk
// domain and deserializes MSB-first words into left/right samples.
//   clk, reset    : system clock (>= 4x BCLK), async active-high reset
//   bclk, lrclk, sdata : codec I2S pins (asynchronous)
//   left_sample, right_sample : last committed words
//   new_sample    : one-clk frame strobe on right commit (after a left commit)
//   framing_error : sticky, set when a slot ends before SAMPLE_WIDTH bits
//   synced        : set on the first LRCLK transition
//
// state     | meaning
// WAIT_SYNC | no LRCLK transition seen yet, data ignored
// SHIFT     | collecting slot bits, count < SAMPLE_WIDTH
// HOLD      | word complete, discarding trailing slot bits
module i2s_line_in_rx
  import i2s_line_in_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bclk,
  input  logic                    lrclk,
  input  logic                    sdata,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    new_sample,
  output logic                    framing_error,
  output logic                    synced
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

  logic                    rise;
  logic [SYNC_STAGES-1:0]  lr_chain;
  logic [SYNC_STAGES-1:0]  sd_chain;
  logic                    lrclk_s;
  logic                    sdata_s;
  logic                    lr_prev;
  logic                    lr_change;
  rx_state_t               state;
  logic [CNT_W-1:0]        count;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic                    chan;
  logic                    have_left;
  logic [CNT_W-1:0]        pad;
  logic [SAMPLE_WIDTH-1:0] commit_word;

  i2s_line_in_rx_sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_bclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bclk),
    .rise  (rise)
  );

  // Same depth as the bclk chain so data and word clock line up with rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_chain <= '0;
      sd_chain <= '0;
    end else begin
      lr_chain <= {lr_chain[SYNC_STAGES-2:0], lrclk};
      sd_chain <= {sd_chain[SYNC_STAGES-2:0], sdata};
    end
  end

  assign lrclk_s   = lr_chain[SYNC_STAGES-1];
  assign sdata_s   = sd_chain[SYNC_STAGES-1];
  assign lr_change = (lrclk_s != lr_prev);

  // Short slots are left-justified: missing LSBs become zero.
  assign pad         = CNT_W'(SAMPLE_WIDTH) - count;
  assign commit_word = shreg << pad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_SYNC;
      count         <= '0;
      shreg         <= '0;
      chan          <= CHAN_LEFT;
      lr_prev       <= 1'b0;
      have_left     <= 1'b0;
      left_sample   <= '0;
      right_sample  <= '0;
      new_sample    <= 1'b0;
      framing_error <= 1'b0;
      synced        <= 1'b0;
    end else begin
      new_sample <= 1'b0;
      if (rise) begin
        lr_prev <= lrclk_s;
        case (state)
          WAIT_SYNC: begin
            if (lr_change) begin
              state  <= SHIFT;
              count  <= '0;
              shreg  <= '0;
              chan   <= lrclk_s;
              synced <= 1'b1;
            end
          end
          SHIFT, HOLD: begin
            if (lr_change) begin
              // The bit on this rise is the I2S delay slot and is dropped.
              if (state == SHIFT && count < CNT_W'(SAMPLE_WIDTH))
                framing_error <= 1'b1;
              if (chan == CHAN_LEFT) begin
                left_sample <= commit_word;
                have_left   <= 1'b1;
              end else begin
                right_sample <= commit_word;
                if (have_left)
                  new_sample <= 1'b1;
              end
              state <= SHIFT;
              count <= '0;
              shreg <= '0;
              chan  <= lrclk_s;
            end else if (state == SHIFT) begin
              shreg <= {shreg[SAMPLE_WIDTH-2:0], sdata_s};
              count <= count + CNT_W'(1);
              if (count == CNT_W'(SAMPLE_WIDTH - 1))
                state <= HOLD;
            end
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// Bench for i2s_line_in_rx: drives an I2S stream at BCLK = clk/8 and checks
// against a slot-level reference model (slots split at LRCLK changes).
module tb_i2s_line_in_rx;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         bclk;
  logic         lrclk;
  logic         sdata;
  logic [W-1:0] left_sample;
  logic [W-1:0] right_sample;
  logic         new_sample;
  logic         framing_error;
  logic         synced;

  always #5 clk = ~clk;

  i2s_line_in_rx #(
    .SAMPLE_WIDTH (W),
    .SYNC_STAGES  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .new_sample    (new_sample),
    .framing_error (framing_error),
    .synced        (synced)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0]  exp_left, exp_right;
  logic          exp_fe, exp_synced, have_left;
  logic          model_prev, model_chan;
  logic          model_bits[$];
  logic [47:0]   exp_q[$];
  int            pulse_cnt = 0;
  bit            slot_open;

  task automatic model_reset();
    exp_left   = '0;
    exp_right  = '0;
    exp_fe     = 1'b0;
    exp_synced = 1'b0;
    have_left  = 1'b0;
    model_prev = 1'b0;
    model_chan = 1'b0;
    model_bits.delete();
    exp_q.delete();
  endtask

  // A finished slot: first W received bits, zero-filled if the slot was short.
  task automatic model_commit();
    logic [W-1:0] word;
    int n;
    n = model_bits.size();
    word = '0;
    for (int i = 0; i < W; i++)
      word[W-1-i] = (i < n) ? model_bits[i] : 1'b0;
    if (n < W) exp_fe = 1'b1;
    if (model_chan == 1'b0) begin
      exp_left  = word;
      have_left = 1'b1;
    end else begin
      exp_right = word;
      if (have_left) exp_q.push_back({exp_left, word});
    end
  endtask

  task automatic model_rise(input logic lr, input logic d);
    if (lr != model_prev) begin
      if (exp_synced) model_commit();
      exp_synced = 1'b1;
      model_chan = lr;
      model_bits.delete();   // delay-slot bit is not part of the word
    end else if (exp_synced) begin
      model_bits.push_back(d);
    end
    model_prev = lr;
  endtask

  always @(negedge clk) begin
    logic [47:0] e;
    if (reset === 1'b0 && new_sample === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 48'(new_sample), 48'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_left", 48'(left_sample), 48'(e[47:24]));
        chk("pulse_right", 48'(right_sample), 48'(e[23:0]));
      end
    end
  end

  task automatic bclk_bit(input logic lr, input logic d);
    @(posedge clk); #1;
    bclk = 1'b0; lrclk = lr; sdata = d;
    repeat (4) @(posedge clk);
    #1 bclk = 1'b1;
    model_rise(lr, d);
    repeat (3) @(posedge clk);
  endtask

  task automatic send_bits(input logic lr, input logic [W-1:0] word, input int from, input int to);
    for (int i = from; i < to; i++) bclk_bit(lr, word[W-1-i]);
  endtask

  task automatic send_slot(input logic lr, input logic [W-1:0] word, input int ndata,
                           input int ntrail, input logic trail);
    if (!(slot_open && lrclk == lr)) bclk_bit(lr, 1'($urandom_range(0, 1)));
    slot_open = 1'b0;
    send_bits(lr, word, 0, ndata);
    for (int i = 0; i < ntrail; i++) bclk_bit(lr, trail);
  endtask

  // Opens the next left slot so the preceding right word commits.
  task automatic close_frame();
    bclk_bit(1'b0, 1'($urandom_range(0, 1)));
    slot_open = 1'b1;
  endtask

  task automatic checkpoint(input string tag);
    @(posedge clk); #1 bclk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_left"}, 48'(left_sample), 48'(exp_left));
    chk({tag, "_right"}, 48'(right_sample), 48'(exp_right));
    chk({tag, "_ferr"}, 48'(framing_error), 48'(exp_fe));
    chk({tag, "_synced"}, 48'(synced), 48'(exp_synced));
    chk({tag, "_pending"}, 48'(exp_q.size()), 48'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_left"}, 48'(left_sample), 48'd0);
    chk({tag, "_right"}, 48'(right_sample), 48'd0);
    chk({tag, "_new"}, 48'(new_sample), 48'd0);
    chk({tag, "_ferr"}, 48'(framing_error), 48'd0);
    chk({tag, "_synced"}, 48'(synced), 48'd0);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_slot(1'b0, l, W, 0, 1'b0);
    send_slot(1'b1, r, W, 0, 1'b0);
    close_frame();
  endtask

  initial begin
    logic [W-1:0] l, r;
    int p;
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    slot_open = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_zero("reset");

    // Stream begins partway through a right slot; right-only start gives no pulse.
    send_slot(1'b1, 24'($urandom), W, 3, 1'b0);
    checkpoint("mid_right");
    send_frame(24'hA5A5A5, 24'h123456);
    checkpoint("nominal");
    chk("nominal_left_const", 48'(left_sample), 48'hA5A5A5);
    chk("nominal_right_const", 48'(right_sample), 48'h123456);

    for (int k = 0; k < 3; k++) begin
      send_frame(24'($urandom), 24'($urandom));
      checkpoint("rand");
    end

    // 32-bit slots with trailing ones
    send_slot(1'b0, 24'h000001, W, 7, 1'b1);
    send_slot(1'b1, 24'h800000, W, 7, 1'b1);
    close_frame();
    checkpoint("slot32");
    chk("slot32_left_const", 48'(left_sample), 48'h000001);
    chk("slot32_right_const", 48'(right_sample), 48'h800000);

    // BCLK stalled high mid-left-word
    l = 24'($urandom); r = 24'($urandom);
    slot_open = 1'b0;
    send_bits(1'b0, l, 0, 10);
    p = pulse_cnt;
    repeat (1000) @(posedge clk);
    #1;
    chk("stall_pulses", 48'(pulse_cnt), 48'(p));
    chk("stall_left", 48'(left_sample), 48'(exp_left));
    chk("stall_right", 48'(right_sample), 48'(exp_right));
    send_bits(1'b0, l, 10, W);
    send_slot(1'b1, r, W, 0, 1'b0);
    close_frame();
    checkpoint("after_stall");

    // Reset in the middle of a left word
    send_bits(1'b0, 24'($urandom), 0, 12);
    @(posedge clk); #1 bclk = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    slot_open = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_zero("mid_reset");
    send_slot(1'b1, 24'($urandom), W, 0, 1'b0);
    send_frame(24'($urandom), 24'($urandom));
    checkpoint("post_reset");

    // Short left slot, then good frames: error stays set
    send_slot(1'b0, 24'hBEEF00, 16, 0, 1'b0);
    send_slot(1'b1, 24'($urandom), W, 0, 1'b0);
    close_frame();
    checkpoint("short");
    chk("short_left_const", 48'(left_sample), 48'hBEEF00);
    chk("short_ferr_const", 48'(framing_error), 48'd1);
    for (int k = 0; k < 2; k++) begin
      send_frame(24'($urandom), 24'($urandom));
      checkpoint("sticky");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_line_in_rx.md
Name: i2s_line_in_rx

Overview:
- Receives the ADAU1761 line-in I2S stream (codec-driven BCLK, LRCLK, serial data) and deserializes it into parallel left/right samples in the clk_100 domain.
- BCLK is oversampled: every codec pin passes through a 2-flop synchronizer, and BCLK rising edges are detected inside clk.
- It is the receive-direction counterpart to the headphone sample path. Its outputs feed the existing line_in sample consumers, and its new_sample pulse serves as the frame strobe.

Parameters:
- SAMPLE_WIDTH, 24, bits captured per channel (MSB first).
- SYNC_STAGES, 2, synchronizer depth on bclk/lrclk/sdata (minimum 2).

Ports:
- clk  input  1  system clock (clk_100); must be at least 4x BCLK.
- reset  input  1  asynchronous, active-high; clears all state.
- bclk  input  1  I2S bit clock from codec (asynchronous).
- lrclk  input  1  I2S word clock; 0 = left, 1 = right (asynchronous).
- sdata  input  1  I2S serial data from codec (asynchronous).
- left_sample  output  SAMPLE_WIDTH  last committed left word.
- right_sample  output  SAMPLE_WIDTH  last committed right word.
- new_sample  output  1  one-clk pulse when a left+right frame has been committed.
- framing_error  output  1  sticky flag for a short slot; cleared only by reset.
- synced  output  1  high once the first LRCLK transition has been seen.

Behaviour:
- Reset values: left_sample=0, right_sample=0, new_sample=0, framing_error=0, synced=0, state=WAIT_SYNC, bit count=0, shift register=0, lr_prev=0.
- Synchronization:
  - bclk, lrclk and sdata all use identical SYNC_STAGES-deep flop chains, so all three are time-aligned.
  - bclk_d is the synced bclk delayed by one more flop.
  - A BCLK rise event (rise) occurs in any clk cycle with bclk_s=1 and bclk_d=0.
  - Nothing advances on cycles without a rise.
- On each rise, lrclk_s and sdata_s are sampled. lr_change = (lrclk_s != lr_prev), after which lr_prev <= lrclk_s.
- States (shared package enum):
  - WAIT_SYNC: ignore data. On lr_change -> SHIFT, count=0, chan=lrclk_s, synced<=1.
  - SHIFT: on rise without lr_change, shift in sdata_s (MSB first) and increment count. When count reaches SAMPLE_WIDTH -> HOLD.
  - HOLD: on rise without lr_change, trailing slot bits are discarded.
  - SHIFT or HOLD with lr_change: commit, then -> SHIFT, count=0, chan=lrclk_s.
- The bit sampled on the lr_change rise is the I2S one-bit delay slot. It is always discarded, and the MSB is taken on the following rise.
- Commit rules:
  - The shift register is written to left_sample (chan=0) or right_sample (chan=1) in the clk cycle after the lr_change rise.
  - Short slot (commit from SHIFT with count<SAMPLE_WIDTH): the word is left-justified with zero LSBs, and framing_error<=1.
  - new_sample pulses for exactly one clk, in the same cycle right_sample updates, but only if a left commit occurred since synced rose. A right-only first slot therefore produces no pulse.
- Latency: last data bit on the sdata pin to the new_sample pulse = SYNC_STAGES+2 clk after the BCLK edge, plus the next rise (delay slot).
- Slot length greater than SAMPLE_WIDTH (e.g. 32-bit slots) is normal: the extra bits are ignored and no error is raised.
- Stalled BCLK: all outputs hold, with no timeout.
- Reset mid-word: everything clears. After reset the block re-enters WAIT_SYNC and discards the partial slot in progress.
- A simultaneous rise and reset deassertion has no effect on that cycle.

Decomposition:
- Shared package: state enum {WAIT_SYNC, SHIFT, HOLD}, constants CHAN_LEFT=0 and CHAN_RIGHT=1.
- One natural sub-module: sync_edge_detect (N-stage synchronizer plus rise output), instantiated for bclk. lrclk and sdata use plain synchronizer chains of equal depth.

Test Plan:
- Nominal 24-bit slots, BCLK=clk/8: send L=0xA5A5A5, R=0x123456 -> left_sample=0xA5A5A5, right_sample=0x123456, one new_sample pulse, framing_error=0.
- 32-bit slots with trailing bits 0xFF: send L=0x000001, R=0x800000 -> samples exact, trailing bits ignored, framing_error=0.
- Start of stream mid-right-slot after reset -> no output until the first LRCLK edge. The first full L/R pair produces the first pulse, and synced rises at the first edge.
- Short slot (LRCLK toggles after 16 bits of L=0xBEEF) -> left_sample=0xBEEF00 and framing_error=1, and it stays 1 across subsequent good frames.
- Reset asserted mid-left-word, then released -> all outputs 0. The next complete frame is captured correctly and the partial word never appears.
- Stalled BCLK for 1000 clk -> outputs hold and new_sample stays 0; capture resumes correctly when BCLK restarts.
